// File: rtl/up_counter_mod_pkg.sv
// up_counter_mod_pkg: shared width default and legal-range limits for the modulo counter.
package up_counter_mod_pkg;
    localparam int WIDTH_DEF = 3;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
endpackage

// File: rtl/up_counter_mod_if.sv
// up_counter_mod_if: control and status bundle of the modulo counter; master drives, slave counts.
interface up_counter_mod_if import up_counter_mod_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;
    modport master(output clr, load, load_val, en, max_val, input count, tc, wrap, ovf);
    modport slave(input clr, load, load_val, en, max_val, output count, tc, wrap, ovf);
endinterface

// File: rtl/up_counter_mod_tc.sv
// up_counter_mod_tc: terminal compare, high while count has reached or passed the terminal value.
module up_counter_mod_tc import up_counter_mod_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_max,
    output logic             o_tc
);
    assign o_tc = i_count >= i_max;
endmodule

// File: rtl/up_counter_mod_async.sv
// up_counter_mod_async: modulo-(max_val+1) up counter, async active-low reset, clr > load > en.
// Define UP_COUNTER_MOD_SAT_EN to saturate at max_val instead of wrapping.
module up_counter_mod_async import up_counter_mod_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic             clk,
    input logic             rst,
    up_counter_mod_if.slave bus
);
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             w_tc;
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("up_counter_mod_async: WIDTH %0d out of range", WIDTH);
    end
    up_counter_mod_tc #(.WIDTH(WIDTH)) u_tc (
        .i_count(r_count),
        .i_max  (bus.max_val),
        .o_tc   (w_tc)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.load) begin
            r_count <= bus.load_val;
            r_wrap  <= 1'b0;
        end else if (bus.en && w_tc) begin
`ifdef UP_COUNTER_MOD_SAT_EN
            r_wrap  <= 1'b0;
`else
            r_count <= '0;
            r_wrap  <= 1'b1;
`endif
            r_ovf   <= 1'b1;
        end else if (bus.en) begin
            r_count <= r_count + 1'b1;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap  <= 1'b0;
        end
    assign bus.count = r_count;
    assign bus.tc    = w_tc;
    assign bus.wrap  = r_wrap;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_up_counter_mod_async.sv
// tb_up_counter_mod_async: directed checks of the modulo counter at WIDTH=3.
module tb_up_counter_mod_async;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    up_counter_mod_if #(.WIDTH(3)) bus ();
    up_counter_mod_async #(.WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
`ifdef UP_COUNTER_MOD_SAT_EN
    localparam logic [2:0] MAXV = 3'd5;
`else
    localparam logic [2:0] MAXV = 3'd7;
`endif
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input int c, input bit w, input bit o);
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
        chk({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(o));
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b0;
        bus.clr = 1'b0;
        bus.load = 1'b0;
        bus.load_val = 3'd0;
        bus.en = 1'b1;
        bus.max_val = MAXV;
        #1;
        chk_all("reset", 0, 0, 0);
        chk("reset.tc", 32'(bus.tc), 32'd0);
        #11;
        rst = 1'b1;
        #1;
        chk_all("release", 0, 0, 0);
`ifdef UP_COUNTER_MOD_SAT_EN
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_all($sformatf("sat%0d", i), i, 0, 0);
        end
        step();
        chk_all("sat_hold1", 5, 0, 1);
        chk("sat_hold1.tc", 32'(bus.tc), 32'd1);
        step();
        chk_all("sat_hold2", 5, 0, 1);
`else
        for (int i = 1; i <= 7; i++) begin
            step();
            chk_all($sformatf("full%0d", i), i, 0, 0);
            chk($sformatf("full%0d.tc", i), 32'(bus.tc), 32'(i == 7));
        end
        step();
        chk_all("full_wrap", 0, 1, 1);
        step();
        chk_all("full_after", 1, 0, 1);
        bus.clr = 1'b1;
        step();
        chk_all("clr", 0, 0, 0);
        bus.clr = 1'b0;
        bus.max_val = 3'd4;
        #1;
        chk("m4.tc0", 32'(bus.tc), 32'd0);
        begin
            int seq [6] = '{1, 2, 3, 4, 0, 1};
            bit eo = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (seq[i] == 0) eo = 1'b1;
                chk_all($sformatf("m4_%0d", i), seq[i], seq[i] == 0, eo);
                chk($sformatf("m4_%0d.tc", i), 32'(bus.tc), 32'(seq[i] == 4));
            end
        end
        bus.load = 1'b1;
        bus.load_val = 3'd3;
        step();
        chk_all("load3", 3, 0, 1);
        bus.load_val = 3'd6;
        step();
        chk_all("load_wins", 6, 0, 1);
        chk("load_wins.tc", 32'(bus.tc), 32'd1);
        bus.load = 1'b0;
        step();
        chk_all("above_max_wrap", 0, 1, 1);
        bus.max_val = 3'd0;
        step();
        chk_all("max0_a", 0, 1, 1);
        chk("max0.tc", 32'(bus.tc), 32'd1);
        step();
        chk_all("max0_b", 0, 1, 1);
        bus.max_val = 3'd7;
        bus.load = 1'b1;
        bus.load_val = 3'd6;
        step();
        chk_all("load6", 6, 0, 1);
        bus.load = 1'b0;
        bus.max_val = 3'd3;
        #1;
        chk("newmax.tc", 32'(bus.tc), 32'd1);
        step();
        chk_all("newmax_wrap", 0, 1, 1);
`endif
        bus.clr = 1'b1;
        bus.load = 1'b1;
        bus.load_val = 3'd5;
        step();
        chk_all("clr_over_load", 0, 0, 0);
        bus.clr = 1'b0;
        bus.en = 1'b0;
        step();
        chk_all("load5", 5, 0, 0);
        bus.load = 1'b0;
        step();
        chk_all("hold", 5, 0, 0);
        bus.en = 1'b1;
        bus.max_val = 3'd4;
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0);
        #2;
        rst = 1'b1;
        step();
        chk_all("post_rst", 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
